// File: rtl/serial_tx.sv
// serial_tx -- parallel-to-serial frame transmitter.
//
// Accepts one DATA_W-bit word over a valid/ready handshake and shifts it out
// on tx_out as: one start bit (0), DATA_W data bits LSB first, one stop bit (1).
// Each bit is held for CLK_DIV clocks. All outputs are registered.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   din        in   word to send, sampled only on the accept edge
//   din_valid  in   producer has a word on din
//   din_ready  out  transmitter can accept a word (registered)
//   tx_out     out  serial line, idles high (registered)
//   busy       out  a frame is in progress (registered)

module serial_tx #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;

  logic              div_end;
  logic [DATA_W-1:0] sh_next;

  assign div_end = (div_cnt == DIV_LAST);
  assign sh_next = shreg >> 1;

  // NOTE: every register here, including the outputs, uses non-blocking
  // assignment so all of them update together from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_out    <= 1'b1;
      din_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_out    <= 1'b1;
          din_ready <= 1'b1;
          busy      <= 1'b0;
          if (din_valid && din_ready) begin
            shreg     <= din;
            div_cnt   <= '0;
            state     <= START;
            din_ready <= 1'b0;
            busy      <= 1'b1;
            // Start bit appears on the line right after the accept edge.
            tx_out    <= 1'b0;
          end
        end

        START: begin
          if (div_end) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= DATA;
            tx_out  <= shreg[0];
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        DATA: begin
          if (div_end) begin
            div_cnt <= '0;
            shreg   <= sh_next;
            if (bit_cnt == BIT_LAST) begin
              state  <= STOP;
              tx_out <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              // tx_out is registered, so it must load the bit that will sit
              // in shreg[0] after this shift, not the current one.
              tx_out  <= sh_next[0];
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        STOP: begin
          if (div_end) begin
            div_cnt   <= '0;
            state     <= IDLE;
            din_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: begin
          state     <= IDLE;
          tx_out    <= 1'b1;
          din_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx -- scoreboard bench for serial_tx.
//
// Two instances: dut_a (DATA_W=8, CLK_DIV=4) and dut_b (DATA_W=4, CLK_DIV=1).
// The stimulus process pushes, once per clock, the expected {tx_out, busy,
// din_ready} seen after that rising edge; a monitor pops on the falling edge
// and compares. Frame levels are hand-computed bit vectors (bit j = level of
// serial bit j, start bit first).

module tb_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset, a_valid, a_ready, a_tx, a_busy;
  logic [7:0] a_din;
  logic       b_reset, b_valid, b_ready, b_tx, b_busy;
  logic [3:0] b_din;

  serial_tx #(.DATA_W(8), .CLK_DIV(4)) dut_a (
    .clk       (clk),
    .reset     (a_reset),
    .din       (a_din),
    .din_valid (a_valid),
    .din_ready (a_ready),
    .tx_out    (a_tx),
    .busy      (a_busy)
  );

  serial_tx #(.DATA_W(4), .CLK_DIV(1)) dut_b (
    .clk       (clk),
    .reset     (b_reset),
    .din       (b_din),
    .din_valid (b_valid),
    .din_ready (b_ready),
    .tx_out    (b_tx),
    .busy      (b_busy)
  );

  typedef struct packed {
    logic tx;
    logic busy;
    logic rdy;
  } exp_t;

  localparam exp_t IDLE_E = '{tx: 1'b1, busy: 1'b0, rdy: 1'b1};

  exp_t qa[$];
  exp_t qb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor: compare whatever the scoreboard expects for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() != 0) begin
      e = qa.pop_front();
      check("A tx_out",    a_tx,    e.tx);
      check("A busy",      a_busy,  e.busy);
      check("A din_ready", a_ready, e.rdy);
    end
    if (qb.size() != 0) begin
      e = qb.pop_front();
      check("B tx_out",    b_tx,    e.tx);
      check("B busy",      b_busy,  e.busy);
      check("B din_ready", b_ready, e.rdy);
    end
  end

  // Advance one clock and queue the state expected after that edge.
  task automatic step(input int dut, input exp_t e);
    @(posedge clk);
    #1;
    if (dut == 0) qa.push_back(e);
    else          qb.push_back(e);
  endtask

  // Inputs must already present the word with valid high. The first step is
  // the accept edge; after it din/valid take nxt_din/nxt_valid. Emits `cut`
  // frame clocks at most, then the IDLE clock if the frame completed.
  task automatic frame(input int dut, input logic [9:0] lv, input int nbits,
                       input int div, input int cut,
                       input logic [7:0] nxt_din, input logic nxt_valid);
    int f;
    f = nbits * div;
    for (int i = 0; i < f && i < cut; i++) begin
      step(dut, {lv[i / div], 1'b1, 1'b0});
      if (i == 0) begin
        if (dut == 0) begin
          a_din   = nxt_din;
          a_valid = nxt_valid;
        end else begin
          b_din   = nxt_din[3:0];
          b_valid = nxt_valid;
        end
      end
    end
    if (cut >= f) step(dut, IDLE_E);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_reset = 1'b1; a_valid = 1'b0; a_din = 8'h00;
    b_reset = 1'b1; b_valid = 1'b0; b_din = 4'h0;

    // Reset state, then 50 idle clocks.
    step(0, IDLE_E);
    a_reset = 1'b0;
    repeat (50) step(0, IDLE_E);

    // 0xA5, then din changes to 0xFF with valid held while busy.
    // Levels start..stop: 0,1,0,1,0,0,1,0,1,1
    a_din   = 8'hA5;
    a_valid = 1'b1;
    frame(0, 10'b11_0100_1010, 10, 4, 1000, 8'hFF, 1'b1);
    // Held valid is taken on the first IDLE clock. Levels: 0,1x8,1
    frame(0, 10'b11_1111_1110, 10, 4, 1000, 8'h00, 1'b0);

    // 0x00 frame, reset asserted 13 clocks in.
    a_din   = 8'h00;
    a_valid = 1'b1;
    frame(0, 10'b10_0000_0000, 10, 4, 13, 8'h00, 1'b0);
    a_reset = 1'b1;
    step(0, IDLE_E);
    a_reset = 1'b0;
    repeat (20) step(0, IDLE_E);

    // Reset and accept on the same edge: reset wins.
    a_reset = 1'b1;
    a_valid = 1'b1;
    a_din   = 8'h3C;
    step(0, IDLE_E);
    a_reset = 1'b0;
    a_valid = 1'b0;
    repeat (5) step(0, IDLE_E);

    // Minimum divider on dut_b: 0x9, levels 0,1,0,0,1,1.
    b_reset = 1'b1;
    step(1, IDLE_E);
    b_reset = 1'b0;
    repeat (3) step(1, IDLE_E);
    b_din   = 4'h9;
    b_valid = 1'b1;
    frame(1, 10'b00_0011_0010, 6, 1, 1000, 8'h00, 1'b0);
    repeat (3) step(1, IDLE_E);

    @(negedge clk);
    #1;
    check("A scoreboard drained", qa.size() == 0, 1'b1);
    check("B scoreboard drained", qb.size() == 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
